// File: rtl/l1_dcache.sv
// l1_dcache: 2-way set-associative, write-back, write-allocate L1 data cache (256 sets x 16-byte lines).
// Define DCACHE_PERF_CNT_EN to add the perf_hit_cnt_o / perf_miss_cnt_o lookup counters.
module l1_dcache #(
    parameter int TAG_W    = 20,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req_i,
    input  logic                                cpu_op_i,
    input  logic [INDEX_W-1:0]                  cpu_index_i,
    input  logic [TAG_W-1:0]                    cpu_tag_i,
    input  logic [OFFSET_W-1:0]                 cpu_offset_i,
    input  logic [DATA_W/8-1:0]                 cpu_wr_en_i,
    input  logic [DATA_W-1:0]                   cpu_wr_data_i,
    output logic [DATA_W-1:0]                   cpu_rd_data_o,
    output logic                                cpu_addr_ack_o,
    output logic                                cpu_data_ack_o,
    output logic                                ram_rd_req_o,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   ram_rd_addr_o,
    input  logic                                ram_rd_rdy_i,
    input  logic [DATA_W-1:0]                   ram_rd_data_i,
    input  logic [2:0]                          ram_rd_num_i,
    input  logic                                ram_wr_rdy_i,
    output logic                                ram_wr_req_o,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   ram_wr_addr_o,
    output logic [(DATA_W<<(OFFSET_W-2))-1:0]   ram_wr_data_o,
    output logic                                ram_dirty_o
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_hit_cnt_o,
    output logic [31:0]                         perf_miss_cnt_o
`endif
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int BANK_W = OFFSET_W - 2;
    localparam int BANKS  = 1 << BANK_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_e;

    typedef struct packed {
        logic                op;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  idx;
        logic [BANK_W-1:0]   bank;
        logic [DATA_W/8-1:0] wen;
        logic [DATA_W-1:0]   wdata;
    } req_t;

    typedef logic [BANKS-1:0][DATA_W-1:0] line_t;

    line_t            data_mem [2][SETS];
    logic [TAG_W-1:0] tag_mem  [2][SETS];

    state_e                  state_q, state_d;
    req_t                    req_q, req_d;
    logic                    vway_q, vway_d;
    logic                    rd_pend_q, rd_pend_d;
    line_t                   line_q, line_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic [1:0][SETS-1:0]    valid_q, valid_d;
    logic [1:0][SETS-1:0]    dirty_q, dirty_d;
    logic [SETS-1:0]         lru_q, lru_d;

    logic        hit0, hit1, hit, hit_way, victim, accept;
    logic        mem_we, tag_we, mem_way;
    line_t       hit_line, fill_line, mem_line;
    logic [DATA_W-1:0] hit_word;

    logic unused_ok;
    assign unused_ok = ^{cpu_offset_i[1:0], ram_rd_num_i[2]};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [DATA_W/8-1:0] be);
        merge_bytes = old_w;
        for (int b = 0; b < DATA_W/8; b++)
            if (be[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
    endfunction

    assign hit0     = valid_q[0][req_q.idx] && (tag_mem[0][req_q.idx] == req_q.tag);
    assign hit1     = valid_q[1][req_q.idx] && (tag_mem[1][req_q.idx] == req_q.tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_line = data_mem[hit_way][req_q.idx];
    assign hit_word = hit_line[req_q.bank];
    // Invalid ways are filled before anything valid is evicted; way0 first.
    assign victim   = !valid_q[0][req_q.idx] ? 1'b0 :
                      !valid_q[1][req_q.idx] ? 1'b1 : lru_q[req_q.idx];

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        vway_d         = vway_q;
        rd_pend_d      = rd_pend_q;
        line_d         = line_q;
        rsp_data_d     = rsp_data_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        lru_d          = lru_q;
        mem_we         = 1'b0;
        tag_we         = 1'b0;
        mem_way        = hit_way;
        mem_line       = hit_line;
        fill_line      = line_q;
        cpu_addr_ack_o = 1'b0;
        cpu_data_ack_o = 1'b0;
        cpu_rd_data_o  = '0;
        accept         = 1'b0;
        case (state_q)
            IDLE: cpu_addr_ack_o = 1'b1;
            LOOKUP: begin
                state_d = IDLE;
                if (hit) begin
                    cpu_data_ack_o      = 1'b1;
                    lru_d[req_q.idx]    = !hit_way;
                    if (req_q.op) begin
                        mem_we                     = 1'b1;
                        mem_line[req_q.bank]       = merge_bytes(hit_word, req_q.wdata, req_q.wen);
                        dirty_d[hit_way][req_q.idx] = 1'b1;
                    end else begin
                        cpu_rd_data_o  = hit_word;
                        cpu_addr_ack_o = 1'b1;
                    end
                end else begin
                    vway_d    = victim;
                    rd_pend_d = 1'b1;
                    state_d   = (valid_q[victim][req_q.idx] && dirty_q[victim][req_q.idx])
                                ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: if (ram_wr_rdy_i) state_d = REFILL;
            REFILL: begin
                if (ram_rd_rdy_i) begin
                    rd_pend_d = 1'b0;
                    fill_line[ram_rd_num_i[BANK_W-1:0]] = ram_rd_data_i;
                    line_d = fill_line;
                    // Last beat: merge any store and install the complete line in one write.
                    if (ram_rd_num_i == 3'(BANKS-1)) begin
                        if (req_q.op)
                            fill_line[req_q.bank] = merge_bytes(fill_line[req_q.bank], req_q.wdata, req_q.wen);
                        mem_we                      = 1'b1;
                        tag_we                      = 1'b1;
                        mem_way                     = vway_q;
                        mem_line                    = fill_line;
                        valid_d[vway_q][req_q.idx]  = 1'b1;
                        dirty_d[vway_q][req_q.idx]  = req_q.op;
                        lru_d[req_q.idx]            = !vway_q;
                        rsp_data_d                  = req_q.op ? '0 : fill_line[req_q.bank];
                        state_d                     = RESPOND;
                    end
                end
            end
            RESPOND: begin
                cpu_data_ack_o = 1'b1;
                cpu_rd_data_o  = rsp_data_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = cpu_req_i && cpu_addr_ack_o;
        if (accept) begin
            req_d.op    = cpu_op_i;
            req_d.tag   = cpu_tag_i;
            req_d.idx   = cpu_index_i;
            req_d.bank  = cpu_offset_i[OFFSET_W-1:2];
            req_d.wen   = cpu_wr_en_i;
            req_d.wdata = cpu_wr_data_i;
            state_d     = LOOKUP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            vway_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            line_q     <= '0;
            rsp_data_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            vway_q     <= vway_d;
            rd_pend_q  <= rd_pend_d;
            line_q     <= line_d;
            rsp_data_q <= rsp_data_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_q      <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) data_mem[mem_way][req_q.idx] <= mem_line;
        if (tag_we) tag_mem[mem_way][req_q.idx]  <= req_q.tag;
    end

    assign ram_wr_req_o  = (state_q == WRITEBACK);
    assign ram_dirty_o   = (state_q == WRITEBACK);
    assign ram_wr_addr_o = ram_wr_req_o ? {tag_mem[vway_q][req_q.idx], req_q.idx, {OFFSET_W{1'b0}}} : '0;
    assign ram_wr_data_o = ram_wr_req_o ? data_mem[vway_q][req_q.idx] : '0;
    assign ram_rd_req_o  = (state_q == REFILL) && rd_pend_q;
    assign ram_rd_addr_o = (state_q == REFILL) ? {req_q.tag, req_q.idx, {OFFSET_W{1'b0}}} : '0;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: load data checked through an expected-response queue, RAM side driven inline.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_i, cpu_op_i;
    logic [7:0]   cpu_index_i;
    logic [19:0]  cpu_tag_i;
    logic [3:0]   cpu_offset_i, cpu_wr_en_i;
    logic [31:0]  cpu_wr_data_i, cpu_rd_data_o;
    logic         cpu_addr_ack_o, cpu_data_ack_o;
    logic         ram_rd_req_o, ram_rd_rdy_i, ram_wr_rdy_i, ram_wr_req_o, ram_dirty_o;
    logic [31:0]  ram_rd_addr_o, ram_rd_data_i, ram_wr_addr_o;
    logic [2:0]   ram_rd_num_i;
    logic [127:0] ram_wr_data_o;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    l1_dcache dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_op_i(cpu_op_i), .cpu_index_i(cpu_index_i),
        .cpu_tag_i(cpu_tag_i), .cpu_offset_i(cpu_offset_i), .cpu_wr_en_i(cpu_wr_en_i),
        .cpu_wr_data_i(cpu_wr_data_i), .cpu_rd_data_o(cpu_rd_data_o),
        .cpu_addr_ack_o(cpu_addr_ack_o), .cpu_data_ack_o(cpu_data_ack_o),
        .ram_rd_req_o(ram_rd_req_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_rdy_i(ram_rd_rdy_i),
        .ram_rd_data_i(ram_rd_data_i), .ram_rd_num_i(ram_rd_num_i), .ram_wr_rdy_i(ram_wr_rdy_i),
        .ram_wr_req_o(ram_wr_req_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_dirty_o(ram_dirty_o)
`ifdef DCACHE_PERF_CNT_EN
        , .perf_hit_cnt_o(perf_hit_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Completion monitor: every data ack pops the oldest expected response.
    always @(negedge clk) begin
        if (!rst && cpu_data_ack_o) begin
            if (exp_q.size() == 0) chk("spurious_data_ack", {127'b0, cpu_data_ack_o}, 128'd0);
            else                   chk("rd_data", {96'b0, cpu_rd_data_o}, {96'b0, exp_q.pop_front()});
        end
        if (ram_wr_req_o) wr_cnt++;
    end

    task automatic issue(input logic op, input logic [19:0] tag, input logic [7:0] idx,
                         input logic [3:0] off, input logic [3:0] wen, input logic [31:0] wd,
                         input logic [31:0] exp);
        int n = 0;
        cpu_req_i = 1'b1; cpu_op_i = op; cpu_tag_i = tag; cpu_index_i = idx;
        cpu_offset_i = off; cpu_wr_en_i = wen; cpu_wr_data_i = wd;
        while (!cpu_addr_ack_o && n < 50) begin cyc(); n++; end
        chk("issue_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        exp_q.push_back(exp);
        cyc();
        cpu_req_i = 1'b0;
    endtask

    task automatic refill(input string nm, input logic [31:0] addr, input logic [3:0][31:0] w);
        int n = 0;
        while (!ram_rd_req_o && n < 50) begin cyc(); n++; end
        chk({nm, "_rd_req"}, {127'b0, ram_rd_req_o}, 128'd1);
        chk({nm, "_rd_addr"}, {96'b0, ram_rd_addr_o}, {96'b0, addr});
        for (int b = 0; b < 4; b++) begin
            ram_rd_rdy_i = 1'b1; ram_rd_num_i = 3'(b); ram_rd_data_i = w[b];
            cyc();
            if (b == 0) chk({nm, "_rd_req_drop"}, {127'b0, ram_rd_req_o}, 128'd0);
        end
        ram_rd_rdy_i = 1'b0;
    endtask

    task automatic writeback(input string nm, input logic [31:0] addr, input logic [127:0] line);
        int n = 0;
        while (!ram_wr_req_o && n < 50) begin cyc(); n++; end
        for (int h = 0; h < 3; h++) begin
            chk({nm, "_wr_req"}, {127'b0, ram_wr_req_o}, 128'd1);
            chk({nm, "_dirty"}, {127'b0, ram_dirty_o}, 128'd1);
            chk({nm, "_wr_addr"}, {96'b0, ram_wr_addr_o}, {96'b0, addr});
            chk({nm, "_wr_data"}, ram_wr_data_o, line);
            chk({nm, "_no_rd_req"}, {127'b0, ram_rd_req_o}, 128'd0);
            cyc();
        end
        ram_wr_rdy_i = 1'b1;
        cyc();
        ram_wr_rdy_i = 1'b0;
        chk({nm, "_wr_drop"}, {127'b0, ram_wr_req_o}, 128'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin cyc(); n++; end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_base;
        rst = 1'b1; cpu_req_i = 0; cpu_op_i = 0; cpu_index_i = 0; cpu_tag_i = 0;
        cpu_offset_i = 0; cpu_wr_en_i = 0; cpu_wr_data_i = 0;
        ram_rd_rdy_i = 0; ram_rd_data_i = 0; ram_rd_num_i = 0; ram_wr_rdy_i = 0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        chk("rst_data_ack", {127'b0, cpu_data_ack_o}, 128'd0);
        chk("rst_rd_data", {96'b0, cpu_rd_data_o}, 128'd0);
        chk("rst_rd_req", {127'b0, ram_rd_req_o}, 128'd0);
        chk("rst_rd_addr", {96'b0, ram_rd_addr_o}, 128'd0);
        chk("rst_wr_req", {127'b0, ram_wr_req_o}, 128'd0);
        chk("rst_wr_addr", {96'b0, ram_wr_addr_o}, 128'd0);
        chk("rst_wr_data", ram_wr_data_o, 128'd0);

        // Cold load miss
        wr_base = wr_cnt;
        issue(0, 20'h00000, 8'h00, 4'b0100, 4'h0, 32'h0, 32'h10101010);
        refill("cold", 32'h00000000, {32'h30303030, 32'h20202020, 32'h10101010, 32'h00000000});
        drain();
        chk("cold_no_wb", 128'(wr_cnt - wr_base), 128'd0);

        // Back-to-back load hits
        issue(0, 20'h00000, 8'h00, 4'b0100, 4'h0, 32'h0, 32'h10101010);
        chk("b2b_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        chk("b2b_first_ack", {127'b0, cpu_data_ack_o}, 128'd1);
        issue(0, 20'h00000, 8'h00, 4'b1000, 4'h0, 32'h0, 32'h20202020);
        chk("b2b_second_ack", {127'b0, cpu_data_ack_o}, 128'd1);

        // Store hit, partial byte enables
        issue(1, 20'h00000, 8'h00, 4'b1000, 4'b0011, 32'hAABBCCDD, 32'h0);
        chk("st_lookup_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd0);
        cyc();
        chk("st_after_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        issue(0, 20'h00000, 8'h00, 4'b1000, 4'h0, 32'h0, 32'h2020CCDD);
        drain();

        // Store with no byte enables leaves the word unchanged
        issue(1, 20'h00000, 8'h00, 4'b0000, 4'b0000, 32'h12345678, 32'h0);
        issue(0, 20'h00000, 8'h00, 4'b0000, 4'h0, 32'h0, 32'h00000000);
        drain();

        // Dirty eviction of the LRU way in set 1
        issue(0, 20'h01010, 8'h01, 4'b0000, 4'h0, 32'h0, 32'h11111110);
        refill("ev_a", 32'h01010010, {32'h11111113, 32'h11111112, 32'h11111111, 32'h11111110});
        drain();
        issue(1, 20'h01010, 8'h01, 4'b0100, 4'hF, 32'hDEADBEEF, 32'h0);
        drain();
        wr_base = wr_cnt;
        issue(0, 20'h02020, 8'h01, 4'b0000, 4'h0, 32'h0, 32'h22222220);
        refill("ev_b", 32'h02020010, {32'h22222223, 32'h22222222, 32'h22222221, 32'h22222220});
        drain();
        chk("ev_b_no_wb", 128'(wr_cnt - wr_base), 128'd0);
        issue(0, 20'h03030, 8'h01, 4'b1100, 4'h0, 32'h0, 32'h33333333);
        writeback("ev", 32'h01010010, {32'h11111113, 32'h11111112, 32'hDEADBEEF, 32'h11111110});
        refill("ev_c", 32'h03030010, {32'h33333333, 32'h33333332, 32'h33333331, 32'h33333330});
        drain();

        // Store miss merge, then eviction shows the line dirty
        issue(1, 20'h04040, 8'h02, 4'b1000, 4'hF, 32'hFFEEDDCC, 32'h0);
        refill("sm", 32'h04040020, {32'h44444443, 32'h44444442, 32'h44444441, 32'h44444440});
        drain();
        issue(0, 20'h04040, 8'h02, 4'b1000, 4'h0, 32'h0, 32'hFFEEDDCC);
        drain();
        issue(0, 20'h05050, 8'h02, 4'b0000, 4'h0, 32'h0, 32'h55555550);
        refill("sm_b", 32'h05050020, {32'h55555553, 32'h55555552, 32'h55555551, 32'h55555550});
        drain();
        issue(0, 20'h06060, 8'h02, 4'b0100, 4'h0, 32'h0, 32'h66666661);
        writeback("sm_ev", 32'h04040020, {32'h44444443, 32'hFFEEDDCC, 32'h44444441, 32'h44444440});
        refill("sm_c", 32'h06060020, {32'h66666663, 32'h66666662, 32'h66666661, 32'h66666660});
        drain();

        // Reset in the middle of a refill
        issue(0, 20'h07070, 8'h03, 4'b0100, 4'h0, 32'h0, 32'h0);
        begin
            int n = 0;
            while (!ram_rd_req_o && n < 50) begin cyc(); n++; end
        end
        chk("mid_rd_addr", {96'b0, ram_rd_addr_o}, 128'h07070030);
        for (int b = 0; b < 2; b++) begin
            ram_rd_rdy_i = 1'b1; ram_rd_num_i = 3'(b); ram_rd_data_i = 32'hBAD0_0000 + b;
            cyc();
        end
        ram_rd_rdy_i = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        chk("mid_rst_rd_req", {127'b0, ram_rd_req_o}, 128'd0);
        chk("mid_rst_data_ack", {127'b0, cpu_data_ack_o}, 128'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_addr_ack", {127'b0, cpu_addr_ack_o}, 128'd1);
        issue(0, 20'h07070, 8'h03, 4'b0100, 4'h0, 32'h0, 32'h77777771);
        refill("re", 32'h07070030, {32'h77777773, 32'h77777772, 32'h77777771, 32'h77777770});
        drain();
        issue(0, 20'h00000, 8'h00, 4'b0100, 4'h0, 32'h0, 32'h10101010);
        refill("re0", 32'h00000000, {32'h30303030, 32'h20202020, 32'h10101010, 32'h00000000});
        drain();

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- 2-way set-associative, write-back, write-allocate L1 data cache.
- Geometry: 256 sets, 16-byte lines (4 banks × 32-bit words), 1-bit LRU per set.
- Sits between the CPU load/store unit (split address/data acknowledge handshake) and the RAM interface module (line refill by 32-bit beats, 128-bit line write-back).

Parameters:
- TAG_W, 20, tag width (address bits 31:12).
- INDEX_W, 8, set index width (address bits 11:4).
- OFFSET_W, 4, byte offset width (address bits 3:0); bank = offset[3:2].
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  CPU request valid
- cpu_op_i  in  1  0=load, 1=store
- cpu_index_i  in  8  set index
- cpu_tag_i  in  20  tag
- cpu_offset_i  in  4  byte offset
- cpu_wr_en_i  in  4  store byte enables
- cpu_wr_data_i  in  32  store data
- cpu_rd_data_o  out  32  load data, valid with cpu_data_ack_o
- cpu_addr_ack_o  out  1  request accepted this cycle when high with cpu_req_i
- cpu_data_ack_o  out  1  one-cycle pulse: request completed
- ram_rd_req_o  out  1  refill request
- ram_rd_addr_o  out  32  refill line address {tag,index,4'b0}
- ram_rd_rdy_i  in  1  refill beat valid
- ram_rd_data_i  in  32  refill beat data
- ram_rd_num_i  in  3  beat number 0..3 (word/bank index)
- ram_wr_rdy_i  in  1  RAM can accept write-back
- ram_wr_req_o  out  1  write-back request
- ram_wr_addr_o  out  32  victim line address {victim_tag,index,4'b0}
- ram_wr_data_o  out  128  victim line, word0 in [31:0]
- ram_dirty_o  out  1  high while ram_wr_req_o carries a dirty line

Behaviour:
- Reset: all valid, dirty and LRU bits cleared; state IDLE; all outputs 0 except cpu_addr_ack_o=1 after reset is released.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- Acceptance: a request is accepted on a clock edge where cpu_req_i && cpu_addr_ack_o. The accepted request is registered and the machine enters LOOKUP.
- cpu_addr_ack_o is high in:
  - IDLE;
  - LOOKUP when the current request is a load hit (back-to-back pipelining).
- cpu_addr_ack_o is low in every other state, including LOOKUP with a store or a miss.
- LOOKUP:
  - Compare the registered tag against both ways' valid tags.
  - Load hit: cpu_data_ack_o=1 and cpu_rd_data_o = hit word of bank offset[3:2], in the cycle after acceptance (1-cycle latency).
  - Store hit: bytes with set cpu_wr_en_i bits are written into the hit word; dirty=1; cpu_data_ack_o=1 the same cycle; cpu_rd_data_o=0.
  - Any hit sets LRU to the other way.
  - Next state: LOOKUP if a new request is accepted, else IDLE.
- Miss victim selection: first invalid way (way0 preferred), else the way indicated by LRU.
  - Victim valid and dirty → WRITEBACK; otherwise → REFILL.
- WRITEBACK:
  - Assert ram_wr_req_o and ram_dirty_o with the address and data held stable.
  - On ram_wr_rdy_i=1 the transfer completes; deassert and go to REFILL.
- REFILL:
  - Assert ram_rd_req_o with ram_rd_addr_o until the first ram_rd_rdy_i beat, then drop it.
  - Each beat with ram_rd_rdy_i=1 writes ram_rd_data_i into the bank given by ram_rd_num_i.
  - After the beat with ram_rd_num_i=3, install the line: tag written; valid=1; dirty=op; LRU points to the other way.
  - Store miss: store bytes are merged into the target word before install.
  - Next state: RESPOND.
- RESPOND: cpu_data_ack_o=1 for one cycle; cpu_rd_data_o = target word for loads, 0 for stores; then IDLE.
- Outputs outside their valid state: ram_wr_data_o, ram_wr_addr_o, ram_rd_addr_o = 0.
- Beats arriving outside REFILL are ignored.
- Reset asserted mid-operation: immediately abort, return to IDLE, clear valid/dirty/LRU; the partially refilled line is discarded.
- cpu_wr_en_i=4'b0000 on a store: it hits/misses normally and still sets dirty, but no bytes change.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, adds outputs perf_hit_cnt_o (32) and perf_miss_cnt_o (32).
  - They count LOOKUP hits and misses respectively.
  - Cleared by rst; wrap around at 2^32.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load miss: tag 0x00000, idx 0x00, off 4'b0100, RAM beats 0..3 = 0x00000000/0x10101010/0x20202020/0x30303030 → ram_rd_addr_o=0x00000000; then cpu_data_ack_o pulse with 0x10101010; ram_wr_req_o never asserted.
- Back-to-back load hits on the line just filled: offsets 4'b0100 then 4'b1000 on consecutive cycles → cpu_addr_ack_o stays 1; data 0x10101010 then 0x20202020 on consecutive cycles.
- Store hit: idx 0, off 4'b1000, wr_en 4'b0011, data 0xAABBCCDD, then load same address → 0x2020CCDD; cpu_addr_ack_o low for exactly the store's LOOKUP cycle.
- Dirty eviction:
  - Fill idx 0x01 with tags 0x01010 and 0x02020, store to tag 0x01010, then load tag 0x03030 to force eviction of 0x01010 (the LRU way).
  - Required: ram_wr_req_o=1 and ram_dirty_o=1 with ram_wr_addr_o=0x01010010 and the modified 128-bit line, held until ram_wr_rdy_i=1; then ram_rd_addr_o=0x03030010.
- Store miss merge: store 0xFFEEDDCC, wr_en 4'b1111, to tag 0x04040 idx 0x02 off 4'b1000 → after refill, a load returns 0xFFEEDDCC; a later eviction of the line shows dirty=1.
- Reset mid-refill after beat 1 → state IDLE, cpu_addr_ack_o=1, and a re-issued load of the same address misses again.
